rf_access_arbiter: RTL and testbench
====================================

// Module: rf_access_arbiter
// PURPOSE
//  Shares the single-port 32x32 register file (REG32 rows + DECODER_5x32 select) between two requesters.
//  Requester 0 is the core datapath; requester 1 is the debug/loader port.
//  Grants one transaction at a time (read or write), sequences RF strobes and handles read latency.
//  Returns completion and read data to the granted requester.
// PARAMETERS
//  ADDR_W    5  register address width
//  DATA_W    32 register data width
//  RD_LAT    1  cycles RF_READ is held before RF_RDATA is valid; legal 1..4
//  PRIO_MODE 0  0 = round-robin, 1 = fixed priority to requester 0 with starvation guard
//  MAX_WAIT  3  PRIO_MODE=1 only: losses by requester 1 before it is forced to win; legal 1..15
// PORTS
//  CLK      in  1         rising-edge clock
//  RESET    in  1         asynchronous, active-high reset
//  REQ      in  2         REQ[i]: requester i has a pending transaction
//  WE       in  2         WE[i]: 1 = write, 0 = read
//  ADDR     in  2*ADDR_W  ADDR[i*ADDR_W +: ADDR_W]: register index for requester i
//  WDATA    in  2*DATA_W  WDATA[i*DATA_W +: DATA_W]: write data for requester i
//  GNT      out 2         one-hot; high from ACCESS through COMPLETE for the owner
//  DONE     out 2         one-cycle completion pulse to the owner
//  RDATA    out DATA_W    last read result; valid when DONE is high for a read
//  RF_ADDR  out ADDR_W    register file address
//  RF_WDATA out DATA_W    register file write data
//  RF_WRITE out 1         register file write strobe, one cycle
//  RF_READ  out 1         register file read enable
//  RF_RDATA in  DATA_W    register file read data
// BEHAVIOUR
//  Reset (async):
//   - state IDLE; GNT, DONE, RF_WRITE and RF_READ are 0.
//   - RDATA, RF_ADDR and RF_WDATA are 0.
//   - last-grant pointer = 1, so requester 0 wins the first tie.
//   - starvation counter = 0.
//  FSM: IDLE -> ACCESS -> [RD_WAIT] -> COMPLETE -> IDLE.
//  IDLE:
//   - arbitrates only when any REQ=1.
//   - latches the winner's WE, ADDR and WDATA at the clock edge (cycle T).
//   - no request -> stays in IDLE.
//  Arbitration:
//   - single requester -> it wins.
//   - both, PRIO_MODE=0 -> the requester not equal to the last-grant pointer wins.
//   - both, PRIO_MODE=1 -> requester 0 wins, unless the starvation counter equals MAX_WAIT; then requester 1 wins.
//   - starvation counter: +1 on each tie lost by requester 1; cleared when requester 1 is granted.
//   - pointer: updated to the winner.
//  ACCESS (T+1):
//   - GNT[w]=1; RF_ADDR and RF_WDATA driven from latched fields (held through COMPLETE).
//   - write: RF_WRITE=1 this cycle only -> COMPLETE.
//   - read: RF_READ=1; RD_LAT=1 -> COMPLETE, else -> RD_WAIT.
//  RD_WAIT:
//   - RF_READ held until it has been high for RD_LAT cycles total (2-bit counter).
//   - RF_RDATA is captured into RDATA on the edge ending cycle T+RD_LAT.
//  COMPLETE:
//   - DONE[w]=1 for one cycle; GNT[w] still 1 -> IDLE.
//   - write total 3 cycles; read total RD_LAT+2 cycles.
//  RDATA: updated only by reads; held until the next read completes.
//  Requester rules:
//   - fields must be valid while REQ is high; they are sampled only in IDLE.
//   - REQ must drop the cycle after DONE unless a new transaction is presented.
//   - REQ high in the IDLE after COMPLETE is a new request.
//  REQ dropped while in flight: ignored; the transaction completes and DONE still pulses.
//  REQ of the non-owner during a transaction: waits; it is considered at the next IDLE.
//  Reset mid-transaction: strobes drop immediately; no DONE; the transaction is lost; RDATA = 0.
//  Address 0 is an ordinary register (no hardwired zero here).
// STRUCTURE
//  Package rf_arb_pkg holds:
//   - state typedef {IDLE, ACCESS, RD_WAIT, COMPLETE}.
//   - ADDR_W/DATA_W defaults.
//   - PRIO_RR=0 and PRIO_FIXED=1 constants.
//  Sub-module rf_arb_pick (combinational): inputs REQ, pointer, starvation count, mode;
//   outputs winner index and any_req.
//  Top holds: FSM, latched request fields, RD_LAT counter, pointer, starvation counter, RDATA register.
// TESTING
//  1. Write, then read back:
//     - REQ=01, WE0=1, ADDR0=5, WDATA0=32'hDEADBEEF
//       -> T+1: RF_WRITE=1, RF_ADDR=5; T+2: DONE=01.
//     - next, a read of addr 5 with RD_LAT=1 -> RDATA=32'hDEADBEEF with DONE=01 at T+2.
//  2. RD_LAT=3, requester 1 reads addr 31
//     -> RF_READ high exactly T+1..T+3; DONE=10 at T+4; RDATA = RF_RDATA sampled at T+3.
//  3. PRIO_MODE=0, REQ=11 held, all writes -> grants alternate 01,10,01,10; first grant 01 after reset.
//  4. PRIO_MODE=1, MAX_WAIT=3, REQ=11 held -> grant sequence 01,01,01,10,01,01,01,10.
//  5. RESET asserted during RD_WAIT
//     -> RF_READ, GNT and DONE go 0 asynchronously; RDATA=0; no DONE after release.
//     -> first post-reset tie grants 01.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file access arbiter.
// Holds the FSM state type, default widths, arbitration mode codes.
package rf_arb_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  localparam logic PRIO_RR    = 1'b0;
  localparam logic PRIO_FIXED = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    RD_WAIT  = 2'd2,
    COMPLETE = 2'd3
  } state_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rf_arb_pick.sv
// Combinational winner selection for the two-requester RF arbiter.
// Ports: i_req, i_ptr (last grant), i_starve, i_mode -> o_winner, o_any_req.
module rf_arb_pick
  import rf_arb_pkg::*;
#(
  parameter int MAX_WAIT = 3
) (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  input  logic [3:0] i_starve,
  input  logic       i_mode,
  output logic       o_winner,
  output logic       o_any_req
);

  logic w_forced;

  // Requester 1 has lost MAX_WAIT ties in a row.
  assign w_forced = (i_starve == 4'(MAX_WAIT));

  always_comb begin
    o_winner = 1'b0;
    unique case (i_req)
      2'b01:   o_winner = 1'b0;
      2'b10:   o_winner = 1'b1;
      2'b11: begin
        if (i_mode == PRIO_RR) o_winner = ~i_ptr;
        else                   o_winner = w_forced;
      end
      default: o_winner = 1'b0;
    endcase
  end

  assign o_any_req = |i_req;

endmodule

// File: rtl/rf_access_arbiter.sv
// Shares a single-port register file between the core (0) and debug (1).
// Ports: CLK/RESET; REQ/WE/ADDR/WDATA in; GNT/DONE/RDATA out;
//        RF_ADDR/RF_WDATA/RF_WRITE/RF_READ to the RF, RF_RDATA back.
module rf_access_arbiter
  import rf_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RD_LAT    = 1,
  parameter int PRIO_MODE = 0,
  parameter int MAX_WAIT  = 3
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [1:0]          REQ,
  input  logic [1:0]          WE,
  input  logic [2*ADDR_W-1:0] ADDR,
  input  logic [2*DATA_W-1:0] WDATA,
  output logic [1:0]          GNT,
  output logic [1:0]          DONE,
  output logic [DATA_W-1:0]   RDATA,
  output logic [ADDR_W-1:0]   RF_ADDR,
  output logic [DATA_W-1:0]   RF_WDATA,
  output logic                RF_WRITE,
  output logic                RF_READ,
  input  logic [DATA_W-1:0]   RF_RDATA
);

  localparam logic       L_MODE = (PRIO_MODE != 0) ? PRIO_FIXED : PRIO_RR;
  localparam logic [1:0] L_LAST = 2'(RD_LAT - 1);

  state_t              r_state;
  logic                r_owner;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [1:0]          r_rd_cnt;
  logic                r_ptr;
  logic [3:0]          r_starve;
  logic [DATA_W-1:0]   r_rdata;

  logic                w_winner;
  logic                w_any_req;
  logic                w_tie;
  logic                w_rd_last;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;

  rf_arb_pick #(
    .MAX_WAIT (MAX_WAIT)
  ) u_pick (
    .i_req     (REQ),
    .i_ptr     (r_ptr),
    .i_starve  (r_starve),
    .i_mode    (L_MODE),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

  assign w_tie   = &REQ;
  assign w_addr  = w_winner ? ADDR[2*ADDR_W-1:ADDR_W]
                            : ADDR[ADDR_W-1:0];
  assign w_wdata = w_winner ? WDATA[2*DATA_W-1:DATA_W]
                            : WDATA[DATA_W-1:0];

  // r_rd_cnt holds (cycles RF_READ has been high) - 1.
  assign w_rd_last = (r_rd_cnt == L_LAST);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= IDLE;
      r_owner  <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rd_cnt <= '0;
      r_ptr    <= 1'b1;
      r_starve <= '0;
      r_rdata  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state  <= ACCESS;
            r_owner  <= w_winner;
            r_we     <= WE[w_winner];
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            r_rd_cnt <= '0;
            r_ptr    <= w_winner;
            if (w_winner) begin
              r_starve <= '0;
            end else if (w_tie && r_starve != 4'hF) begin
              r_starve <= r_starve + 4'd1;
            end
          end
        end
        ACCESS, RD_WAIT: begin
          if (r_we) begin
            r_state <= COMPLETE;
          end else if (w_rd_last) begin
            r_rdata <= RF_RDATA;
            r_state <= COMPLETE;
          end else begin
            r_rd_cnt <= r_rd_cnt + 2'd1;
            r_state  <= RD_WAIT;
          end
        end
        COMPLETE: r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase
    end
  end

  // Strobes decode from state so reset removes them asynchronously.
  assign GNT      = (r_state != IDLE) ? onehot2(r_owner) : 2'b00;
  assign DONE     = (r_state == COMPLETE) ? onehot2(r_owner) : 2'b00;
  assign RF_WRITE = (r_state == ACCESS) && r_we;
  assign RF_READ  = ((r_state == ACCESS) || (r_state == RD_WAIT)) && !r_we;
  assign RF_ADDR  = r_addr;
  assign RF_WDATA = r_wdata;
  assign RDATA    = r_rdata;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Bench for rf_access_arbiter: two instances (RR/lat1, fixed/lat3).
// Transaction-level model predicts winner, timing and read data.
module tb_rf_access_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: round-robin, RD_LAT=1
  logic [1:0]  a_req, a_we, a_gnt, a_done;
  logic [9:0]  a_addr;
  logic [63:0] a_wdata;
  logic [31:0] a_rdata, a_rf_wdata, a_rf_rdata;
  logic [4:0]  a_rf_addr;
  logic        a_rf_write, a_rf_read;

  // Instance B: fixed priority, MAX_WAIT=3, RD_LAT=3
  logic [1:0]  b_req, b_we, b_gnt, b_done;
  logic [9:0]  b_addr;
  logic [63:0] b_wdata;
  logic [31:0] b_rdata, b_rf_wdata, b_rf_rdata;
  logic [4:0]  b_rf_addr;
  logic        b_rf_write, b_rf_read;

  rf_access_arbiter #(
    .ADDR_W(5), .DATA_W(32), .RD_LAT(1), .PRIO_MODE(0), .MAX_WAIT(3)
  ) dut_a (
    .CLK(clk), .RESET(rst), .REQ(a_req), .WE(a_we),
    .ADDR(a_addr), .WDATA(a_wdata), .GNT(a_gnt), .DONE(a_done),
    .RDATA(a_rdata), .RF_ADDR(a_rf_addr), .RF_WDATA(a_rf_wdata),
    .RF_WRITE(a_rf_write), .RF_READ(a_rf_read), .RF_RDATA(a_rf_rdata)
  );

  rf_access_arbiter #(
    .ADDR_W(5), .DATA_W(32), .RD_LAT(3), .PRIO_MODE(1), .MAX_WAIT(3)
  ) dut_b (
    .CLK(clk), .RESET(rst), .REQ(b_req), .WE(b_we),
    .ADDR(b_addr), .WDATA(b_wdata), .GNT(b_gnt), .DONE(b_done),
    .RDATA(b_rdata), .RF_ADDR(b_rf_addr), .RF_WDATA(b_rf_wdata),
    .RF_WRITE(b_rf_write), .RF_READ(b_rf_read), .RF_RDATA(b_rf_rdata)
  );

  // Register file seen by instance A
  logic [31:0] a_rf_mem [32] = '{default: '0};
  always @(posedge clk)
    if (a_rf_write) a_rf_mem[a_rf_addr] <= a_rf_wdata;
  assign a_rf_rdata = a_rf_mem[a_rf_addr];

  // Reference model state
  bit [31:0] a_mem [32];
  bit        a_ptr, b_ptr;
  int        a_starve, b_starve;
  bit [31:0] a_rdx, b_rdx;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Winner per arbitration rules.
  function automatic bit model_pick(input bit [1:0] req, input bit ptr,
                                    input int starve, input bit fixed,
                                    input int maxw);
    if (req == 2'b01) return 1'b0;
    if (req == 2'b10) return 1'b1;
    if (!fixed) return !ptr;
    return starve >= maxw;
  endfunction

  task automatic a_txn(input bit [1:0] req, input bit [1:0] we,
                       input bit [4:0] ad0, input bit [4:0] ad1,
                       input bit [31:0] d0, input bit [31:0] d1);
    bit        w;
    bit [4:0]  ad;
    bit [31:0] d;
    chk("a_idle_gnt", a_gnt, 2'b00);
    chk("a_rdata_hold", a_rdata, a_rdx);
    a_req = req; a_we = we;
    a_addr = {ad1, ad0}; a_wdata = {d1, d0};
    w  = model_pick(req, a_ptr, a_starve, 1'b0, 3);
    ad = w ? ad1 : ad0;
    d  = w ? d1 : d0;
    if (w) a_starve = 0;
    else if (req == 2'b11) a_starve++;
    a_ptr = w;
    tick;
    chk("a_acc_gnt", a_gnt, w ? 2'b10 : 2'b01);
    chk("a_acc_addr", a_rf_addr, ad);
    chk("a_acc_write", a_rf_write, we[w]);
    chk("a_acc_read", a_rf_read, !we[w]);
    chk("a_acc_done", a_done, 2'b00);
    if (we[w]) chk("a_acc_wdata", a_rf_wdata, d);
    tick;
    if (we[w]) a_mem[ad] = d;
    else       a_rdx = a_mem[ad];
    chk("a_cmp_done", a_done, w ? 2'b10 : 2'b01);
    chk("a_cmp_gnt", a_gnt, w ? 2'b10 : 2'b01);
    chk("a_cmp_strobes", {a_rf_write, a_rf_read}, 2'b00);
    chk("a_cmp_rdata", a_rdata, a_rdx);
    tick;
  endtask

  task automatic b_txn(input bit [1:0] req, input bit [1:0] we,
                       input bit [4:0] ad0, input bit [4:0] ad1,
                       input bit [31:0] d0, input bit [31:0] d1);
    bit        w;
    bit [4:0]  ad;
    bit [31:0] v;
    chk("b_idle_gnt", b_gnt, 2'b00);
    chk("b_rdata_hold", b_rdata, b_rdx);
    b_req = req; b_we = we;
    b_addr = {ad1, ad0}; b_wdata = {d1, d0};
    w  = model_pick(req, b_ptr, b_starve, 1'b1, 3);
    ad = w ? ad1 : ad0;
    if (w) b_starve = 0;
    else if (req == 2'b11) b_starve++;
    b_ptr = w;
    tick;
    chk("b_acc_gnt", b_gnt, w ? 2'b10 : 2'b01);
    chk("b_acc_addr", b_rf_addr, ad);
    chk("b_acc_write", b_rf_write, we[w]);
    if (we[w]) begin
      chk("b_acc_wdata", b_rf_wdata, w ? d1 : d0);
      tick;
    end else begin
      for (int k = 1; k <= 3; k++) begin
        chk("b_rd_hold", b_rf_read, 1'b1);
        chk("b_rd_gnt", b_gnt, w ? 2'b10 : 2'b01);
        chk("b_rd_done", b_done, 2'b00);
        v = $urandom;
        b_rf_rdata = v;
        if (k == 3) b_rdx = v;
        tick;
      end
      b_rf_rdata = ~b_rdx;
    end
    chk("b_cmp_done", b_done, w ? 2'b10 : 2'b01);
    chk("b_cmp_gnt", b_gnt, w ? 2'b10 : 2'b01);
    chk("b_cmp_strobes", {b_rf_write, b_rf_read}, 2'b00);
    chk("b_cmp_rdata", b_rdata, b_rdx);
    tick;
  endtask

  initial begin
    rst = 1'b1;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    b_rf_rdata = 0;
    a_ptr = 1'b1; b_ptr = 1'b1;
    a_starve = 0; b_starve = 0;
    a_rdx = 0; b_rdx = 0;
    #1;
    chk("rst_a_gnt_done", {a_gnt, a_done}, 4'h0);
    chk("rst_a_strobes", {a_rf_write, a_rf_read}, 2'b00);
    chk("rst_a_rdata", a_rdata, 32'h0);
    chk("rst_a_rf_addr", a_rf_addr, 5'h0);
    chk("rst_a_rf_wdata", a_rf_wdata, 32'h0);
    chk("rst_b_gnt_done", {b_gnt, b_done}, 4'h0);
    chk("rst_b_strobes", {b_rf_write, b_rf_read}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    tick;

    // Idle with no request stays idle
    tick;
    chk("a_noreq_gnt", a_gnt, 2'b00);

    // Round-robin ties alternate, requester 0 first
    for (int i = 0; i < 4; i++)
      a_txn(2'b11, 2'b11, 5'(i), 5'(i + 8), $urandom, $urandom);

    // Write then read back address 5
    a_txn(2'b01, 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0);
    a_txn(2'b01, 2'b00, 5'd5, 5'd0, 32'h0, 32'h0);
    chk("a_readback", a_rdata, 32'hDEADBEEF);

    // Address 0 is an ordinary register
    a_txn(2'b10, 2'b10, 5'd0, 5'd0, 32'h0, 32'h1234_5678);
    a_txn(2'b01, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    chk("a_addr0", a_rdata, 32'h1234_5678);

    // Random mix on instance A
    for (int i = 0; i < 30; i++)
      a_txn(2'($urandom_range(1, 3)), 2'($urandom),
            5'($urandom), 5'($urandom), $urandom, $urandom);

    // Leave pointer at 0 before the reset test
    a_txn(2'b01, 2'b01, 5'd1, 5'd0, 32'h55, 32'h0);
    a_req = 2'b00;

    // Fixed priority with starvation guard: 01,01,01,10 x2
    for (int i = 0; i < 8; i++)
      b_txn(2'b11, 2'b11, 5'(i), 5'(i + 16), $urandom, $urandom);

    // Requester 1 reads address 31, RD_LAT=3
    b_txn(2'b10, 2'b00, 5'd0, 5'd31, 32'h0, 32'h0);

    for (int i = 0; i < 8; i++)
      b_txn(2'($urandom_range(1, 3)), 2'($urandom),
            5'($urandom), 5'($urandom), $urandom, $urandom);

    // Reset during RD_WAIT
    chk("b_pre_idle", b_gnt, 2'b00);
    b_req = 2'b10; b_we = 2'b00; b_addr = {5'd31, 5'd0};
    b_rf_rdata = 32'hCAFE_F00D;
    tick;
    tick;
    chk("b_rdwait_read", b_rf_read, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("b_rst_read", b_rf_read, 1'b0);
    chk("b_rst_gnt", b_gnt, 2'b00);
    chk("b_rst_done", b_done, 2'b00);
    chk("b_rst_rdata", b_rdata, 32'h0);
    chk("a_rst_rdata", a_rdata, 32'h0);
    b_req = 2'b00;
    a_ptr = 1'b1; b_ptr = 1'b1;
    a_starve = 0; b_starve = 0;
    a_rdx = 0; b_rdx = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("b_no_done_after_rst", {b_done, b_gnt}, 4'h0);
    end

    // First ties after reset go to requester 0
    a_txn(2'b11, 2'b11, 5'd2, 5'd3, 32'h11, 32'h22);
    a_req = 2'b00;
    b_txn(2'b11, 2'b11, 5'd2, 5'd3, 32'h11, 32'h22);
    b_req = 2'b00;

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
